// File: rtl/overflow_flag_pkg.sv
// overflow_flag_pkg: shared ALU opcode type and constants
package overflow_flag_pkg;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_AND = 4'd0;
  localparam alu_op_t ALU_OR  = 4'd1;
  localparam alu_op_t ALU_XOR = 4'd2;
  localparam alu_op_t ALU_NOT = 4'd3;
  localparam alu_op_t ALU_SHL = 4'd4;
  localparam alu_op_t ALU_SHR = 4'd5;
  localparam alu_op_t ALU_SRA = 4'd6;
  localparam alu_op_t ALU_MOV = 4'd7;
  localparam alu_op_t ALU_ADD = 4'd8;
  localparam alu_op_t ALU_SUB = 4'd9;
  localparam alu_op_t ALU_CMP = 4'd10;
endpackage

// File: rtl/overflow_flag_detect.sv
// overflow_detect: two's-complement overflow rule from sign bits and opcode
module overflow_detect
  import overflow_flag_pkg::*;
#(
  parameter alu_op_t OP_ADD = ALU_ADD,
  parameter alu_op_t OP_SUB = ALU_SUB,
  parameter alu_op_t OP_CMP = ALU_CMP
) (
  input  logic    a_msb,
  input  logic    b_msb,
  input  logic    result_msb,
  input  alu_op_t alu_control,
  output logic    overflow
);
  logic is_add, is_sub;
  assign is_add = alu_control == OP_ADD;
  assign is_sub = alu_control == OP_SUB || alu_control == OP_CMP;
  assign overflow = (result_msb != a_msb) && (is_add ? a_msb == b_msb : is_sub && a_msb != b_msb);
endmodule

// File: rtl/overflow_flag.sv
// overflow_flag: combinational, registered and sticky signed-overflow flags
module overflow_flag
  import overflow_flag_pkg::*;
#(
  parameter alu_op_t OP_ADD = ALU_ADD,
  parameter alu_op_t OP_SUB = ALU_SUB,
  parameter alu_op_t OP_CMP = ALU_CMP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_msb,
  input  logic       b_msb,
  input  logic       result_msb,
  input  logic [3:0] alu_control,
  input  logic       flag_en,
  input  logic       sticky_clr,
  output logic       overflow,
  output logic       overflow_q,
  output logic       overflow_sticky
);
  logic flag_d, sticky_d, sticky_q;
  overflow_detect #(.OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .OP_CMP(OP_CMP)) u_detect (
    .a_msb(a_msb),
    .b_msb(b_msb),
    .result_msb(result_msb),
    .alu_control(alu_control),
    .overflow(overflow)
  );
  // next state: load flag on enable; a latched overflow beats a clear
  always_comb begin
    flag_d = flag_en ? overflow : overflow_q;
    sticky_d = (flag_en && overflow) ? 1'b1 : (sticky_clr ? 1'b0 : sticky_q);
  end
  // flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      overflow_q <= flag_d;
      sticky_q <= sticky_d;
    end
  end
  assign overflow_sticky = sticky_q;
endmodule

// File: tb/tb_overflow_flag.sv
// tb_overflow_flag: random and directed checks against an arithmetic reference
module tb_overflow_flag;
  logic clk = 1'b0, rst_n, a_msb, b_msb, result_msb, flag_en, sticky_clr;
  logic [3:0] alu_control;
  logic overflow, overflow_q, overflow_sticky;
  logic exp_ov, exp_q, exp_s;
  int checks = 0, failures = 0;

  overflow_flag dut (
    .clk(clk), .rst_n(rst_n), .a_msb(a_msb), .b_msb(b_msb), .result_msb(result_msb),
    .alu_control(alu_control), .flag_en(flag_en), .sticky_clr(sticky_clr),
    .overflow(overflow), .overflow_q(overflow_q), .overflow_sticky(overflow_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // drive operands as real 4-bit values; expected overflow = true signed result out of range
  task automatic apply(logic [3:0] a, logic [3:0] b, logic [3:0] op, logic fe, logic clr);
    int sa, sb, s;
    logic [3:0] r;
    bit sub, arith;
    sa = $signed(a);
    sb = $signed(b);
    sub = op == 4'd9 || op == 4'd10;
    arith = sub || op == 4'd8;
    s = sub ? sa - sb : sa + sb;
    r = s[3:0];
    a_msb = a[3];
    b_msb = b[3];
    result_msb = r[3];
    alu_control = op;
    flag_en = fe;
    sticky_clr = clr;
    exp_ov = arith && (s > 7 || s < -8);
  endtask

  task automatic cycle(string tag);
    #1 check({tag, "_comb"}, overflow, exp_ov);
    if (!rst_n) begin
      exp_q = 1'b0;
      exp_s = 1'b0;
    end else begin
      if (flag_en) exp_q = exp_ov;
      if (flag_en && exp_ov) exp_s = 1'b1;
      else if (sticky_clr) exp_s = 1'b0;
    end
    @(posedge clk);
    #1 check({tag, "_q"}, overflow_q, exp_q);
    check({tag, "_sticky"}, overflow_sticky, exp_s);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    apply(4'b0111, 4'b0011, 4'd8, 1'b1, 1'b0);
    cycle("rst0");
    cycle("rst1");
    rst_n = 1'b1;
    apply(4'b0111, 4'b0011, 4'd8, 1'b1, 1'b0);
    cycle("add_ov");
    apply(4'b0010, 4'b0011, 4'd8, 1'b1, 1'b0);
    cycle("add_noov");
    apply(4'b1111, 4'b0011, 4'd8, 1'b1, 1'b0);
    cycle("add_mixed");
    apply(4'b0111, 4'b0011, 4'd8, 1'b1, 1'b0);
    cycle("reload");
    apply(4'b0010, 4'b0011, 4'd8, 1'b0, 1'b0);
    cycle("hold");
    apply(4'b0111, 4'b1000, 4'd9, 1'b0, 1'b0);
    cycle("sub_ov");
    apply(4'b1001, 4'b1000, 4'd9, 1'b0, 1'b0);
    cycle("sub_noov");
    apply(4'b1000, 4'b0001, 4'd10, 1'b0, 1'b0);
    cycle("cmp_ov");
    apply(4'b0111, 4'b0011, 4'd0, 1'b0, 1'b0);
    cycle("op0");
    apply(4'b0111, 4'b0011, 4'd8, 1'b1, 1'b1);
    cycle("set_wins");
    apply(4'b0010, 4'b0011, 4'd8, 1'b1, 1'b1);
    cycle("clr");
    apply(4'b0111, 4'b0011, 4'd8, 1'b1, 1'b0);
    cycle("preset");
    rst_n = 1'b0;
    apply(4'b0111, 4'b1000, 4'd9, 1'b1, 1'b0);
    #1 check("sync_rst_q", overflow_q, exp_q);
    check("sync_rst_sticky", overflow_sticky, exp_s);
    cycle("sync_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) < 3) ? 4'(8 + $urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      rst_n = $urandom_range(0, 19) != 0;
      apply(4'($urandom), 4'($urandom), op, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      cycle("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/overflow_flag.md
Name: overflow_flag

Overview:
Signed-overflow detector for the ALU flag logic. It takes the sign bits (MSBs) of both operands and of the ALU result, plus the 4-bit ALU control code, and flags two's-complement overflow for add and subtract-type operations. It has three outputs:
- a combinational overflow output, which feeds the ALU flag bus directly;
- a registered flag (V of the status register);
- a sticky overflow status bit.

Parameters:
- OP_ADD, 4'd8, ALU control code for addition
- OP_SUB, 4'd9, ALU control code for subtraction (a - b)
- OP_CMP, 4'd10, ALU control code for compare; same overflow rule as subtraction, result not written back

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- a_msb  input  1  sign bit of operand A
- b_msb  input  1  sign bit of operand B
- result_msb  input  1  sign bit of the ALU result
- alu_control  input  4  ALU operation code
- flag_en  input  1  load enable for the registered flag
- sticky_clr  input  1  clears the sticky status bit
- overflow  output  1  combinational overflow, same cycle as inputs
- overflow_q  output  1  registered overflow flag
- overflow_sticky  output  1  set on any latched overflow, held until cleared

Behaviour:
- overflow is purely combinational, with zero latency. It does not depend on clk or rst_n.
- Add (alu_control == OP_ADD): overflow = (a_msb == b_msb) && (result_msb != a_msb).
- Sub/Cmp (alu_control == OP_SUB or OP_CMP): overflow = (a_msb != b_msb) && (result_msb != a_msb).
- Any other alu_control value (logic, shifts, moves): overflow = 0.
- Inputs containing X/Z need not produce a defined result. With all inputs at 0/1 the output is never X.
- overflow_q is updated on the rising clk edge:
  - if rst_n == 0: overflow_q <= 0;
  - else if flag_en: overflow_q <= overflow;
  - else: overflow_q holds.
- overflow_sticky is updated on the rising clk edge:
  - if rst_n == 0: overflow_sticky <= 0;
  - else if flag_en && overflow: overflow_sticky <= 1 (set wins over a simultaneous sticky_clr);
  - else if sticky_clr: overflow_sticky <= 0;
  - else: overflow_sticky holds.
- Reset values: overflow_q = 0 and overflow_sticky = 0. overflow keeps following its inputs during reset.
- Reset mid-operation: a pending flag_en in the reset cycle is ignored.
- Registered outputs reflect the overflow value present in the cycle in which flag_en was sampled high, i.e. one cycle of latency.
- The block has no state machine.

Decomposition:
- Shared ALU package: the alu_control opcode constants (OP_ADD, OP_SUB, OP_CMP and the other ALU opcodes) and a 4-bit alu_op_t typedef. The parameters default to these constants.
- One sub-module is natural: overflow_detect, the combinational rule evaluation (MSBs + opcode -> overflow). The top level adds the two registers.

Test Plan:
- Add, alu_control=8, a=0111, b=0011, result=1010 (MSBs 0,0,1) -> overflow=1 combinationally, with no clock edge needed.
- Add, a=0010, b=0011, result=0101 (MSBs 0,0,0) -> overflow=0. Add, a=1111, b=0011, result=0010 (MSBs 1,0,0) -> overflow=0.
- Sub, alu_control=9, a=0111, b=1000, result=1111 (MSBs 0,1,1) -> overflow=1. Sub with MSBs 1,1,0 -> 0. Cmp (10) with MSBs 1,0,0 -> 1. Opcode 4'd0 with MSBs 0,0,1 -> 0.
- Registered flag: with rst_n=0 for 2 cycles, then rst_n=1, outputs are overflow_q=0 and overflow_sticky=0.
  - Apply an overflowing add with flag_en=1 for 1 cycle -> overflow_q=1 and overflow_sticky=1 after that edge.
  - Next, a non-overflowing add with flag_en=1 -> overflow_q=0, sticky stays 1.
  - flag_en=0 -> overflow_q holds.
- Sticky priority: flag_en=1, overflow=1 and sticky_clr=1 in the same cycle -> sticky=1. Next cycle, sticky_clr=1 with no overflow -> sticky=0.
- Synchronous reset: drop rst_n with no clock edge -> registers unchanged. After the next edge -> both registers 0, and overflow still tracks its inputs.
